// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the host bridge, the RISC-V data port, the arbiter and
// the shared single-port memory. The arbiter takes the slave view; the
// environment (bridge, core, memory) takes the master view.
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int STALL_W = 16
);
  localparam int STRB_W = DATA_W / 8;

  // Host (AXI-Lite MMIO bridge) side
  logic [ADDR_W-1:0]  host_addr;
  logic [DATA_W-1:0]  host_wdata;
  logic               host_we;
  logic               host_re;
  logic [DATA_W-1:0]  host_rdata;

  // RISC-V core data port
  logic               cpu_req;
  logic               cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [DATA_W-1:0]  cpu_wdata;
  logic [STRB_W-1:0]  cpu_wstrb;
  logic               cpu_gnt;
  logic               cpu_done;
  logic [DATA_W-1:0]  cpu_rdata;
  logic [STALL_W-1:0] stall_cnt;

  // Shared memory port
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [STRB_W-1:0]  mem_wstrb;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_rdata;

  modport slave (
    input  host_addr, host_wdata, host_we, host_re,
    output host_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_gnt, cpu_done, cpu_rdata, stall_cnt,
    output mem_addr, mem_wdata, mem_wstrb, mem_we,
    input  mem_rdata
  );

  modport master (
    output host_addr, host_wdata, host_we, host_re,
    input  host_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_gnt, cpu_done, cpu_rdata, stall_cnt,
    input  mem_addr, mem_wdata, mem_wstrb, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Arbiter for the single-port instruction/data memory. The host bridge has
// absolute priority and is served combinationally in its pulse cycle; the
// RISC-V data port is accepted in IDLE, performed in ACCESS on the first
// host-free cycle, and acknowledged with a one-cycle done pulse.
module riscv_mem_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int STALL_W = 16
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESETN,
  input  logic riscv_rst,
  riscv_mem_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               host_act_s;
  logic               cpu_gnt_s;
  logic               cpu_go_s;

  logic               req_we_r;
  logic [ADDR_W-1:0]  req_addr_r;
  logic [DATA_W-1:0]  req_wdata_r;
  logic [STRB_W-1:0]  req_wstrb_r;

  logic               cpu_done_r;
  logic [DATA_W-1:0]  cpu_rdata_r;
  logic [STALL_W-1:0] stall_cnt_r;

  logic [ADDR_W-1:0]  mem_addr_s;
  logic [DATA_W-1:0]  mem_wdata_s;
  logic [STRB_W-1:0]  mem_wstrb_s;
  logic               mem_we_s;

  assign host_act_s = bus.host_we | bus.host_re;

  // Next-state logic: grant in IDLE, wait out host cycles in ACCESS, riscv_rst aborts
  always_comb begin
    state_nxt_s = state_r;
    cpu_gnt_s   = 1'b0;
    cpu_go_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cpu_gnt_s = bus.cpu_req & ~riscv_rst;
        if (cpu_gnt_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (riscv_rst) begin
          state_nxt_s = ST_IDLE;
        end else if (host_act_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          cpu_go_s    = 1'b1;
          state_nxt_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Memory port mux: host first, then a CPU access being performed, else parked at zero
  always_comb begin
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    mem_wstrb_s = {STRB_W{1'b0}};
    mem_we_s    = 1'b0;
    if (host_act_s) begin
      mem_addr_s  = bus.host_addr;
      mem_wdata_s = bus.host_wdata;
      mem_wstrb_s = {STRB_W{bus.host_we}};
      mem_we_s    = bus.host_we;
    end else if (cpu_go_s) begin
      mem_addr_s  = req_addr_r;
      mem_wdata_s = req_wdata_r;
      mem_wstrb_s = req_we_r ? req_wstrb_r : {STRB_W{1'b0}};
      mem_we_s    = req_we_r;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the CPU request at grant so the core may change its bus afterwards
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      req_we_r    <= 1'b0;
      req_addr_r  <= {ADDR_W{1'b0}};
      req_wdata_r <= {DATA_W{1'b0}};
      req_wstrb_r <= {STRB_W{1'b0}};
    end else if (cpu_gnt_s) begin
      req_we_r    <= bus.cpu_we;
      req_addr_r  <= bus.cpu_addr;
      req_wdata_r <= bus.cpu_wdata;
      req_wstrb_r <= bus.cpu_wstrb;
    end
  end

  // Completion pulse and read data; a CPU write leaves the last read data untouched
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      cpu_done_r  <= 1'b0;
      cpu_rdata_r <= {DATA_W{1'b0}};
    end else begin
      cpu_done_r <= (state_nxt_s == ST_DONE);
      if (cpu_go_s && !req_we_r) begin
        cpu_rdata_r <= bus.mem_rdata;
      end
    end
  end

  // Saturating count of ACCESS cycles lost to the host; held at zero while the core is in reset
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      stall_cnt_r <= {STALL_W{1'b0}};
    end else if (riscv_rst) begin
      stall_cnt_r <= {STALL_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && host_act_s && (stall_cnt_r != STALL_MAX)) begin
      stall_cnt_r <= stall_cnt_r + STALL_ONE;
    end
  end

  assign bus.host_rdata = bus.mem_rdata;
  assign bus.cpu_gnt    = cpu_gnt_s;
  assign bus.cpu_done   = cpu_done_r;
  assign bus.cpu_rdata  = cpu_rdata_r;
  assign bus.stall_cnt  = stall_cnt_r;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;
  assign bus.mem_wstrb  = mem_wstrb_s;
  assign bus.mem_we     = mem_we_s;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: behavioural memory, a transaction-level
// reference model of host/CPU sharing, directed scenarios and random traffic.
module tb_riscv_mem_arbiter;
  logic clk;
  logic rst_n;
  logic riscv_rst;

  riscv_mem_arbiter_if #(.ADDR_W(11), .DATA_W(32), .STALL_W(16)) bif ();

  riscv_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .STALL_W(16)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .riscv_rst     (riscv_rst),
    .bus           (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory the arbiter actually drives
  logic [31:0] mem_arr [0:2047];
  assign bif.mem_rdata = mem_arr[bif.mem_addr];

  // Byte-enabled write into the bench memory
  always @(posedge clk) begin
    if (bif.mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bif.mem_wstrb[b]) mem_arr[bif.mem_addr][8*b +: 8] <= bif.mem_wdata[8*b +: 8];
      end
    end
  end

  // Reference model: memory contents plus the one outstanding CPU transaction
  logic [31:0] m_mem [0:2047];
  logic        m_pend, m_done, m_we;
  logic [10:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic [15:0] m_stall;
  logic        last_gnt;
  logic        prev_host;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_done = 1'b0; m_we = 1'b0; m_addr = 11'd0;
    m_wdata = 32'd0; m_rdata = 32'd0; m_strb = 4'd0; m_stall = 16'd0;
  endtask

  // One clock cycle: inputs are already driven; check, clock, advance the model
  task automatic step();
    logic        host_act, perform, exp_gnt, exp_we;
    logic [10:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    #2;
    host_act = bif.host_we | bif.host_re;
    exp_gnt  = bif.cpu_req & ~riscv_rst & ~m_pend & ~m_done;
    perform  = m_pend & ~host_act & ~riscv_rst;
    if (host_act) begin
      exp_we = bif.host_we; exp_addr = bif.host_addr; exp_wdata = bif.host_wdata; exp_strb = 4'hF;
    end else if (perform) begin
      exp_we = m_we; exp_addr = m_addr; exp_wdata = m_wdata; exp_strb = m_strb;
    end else begin
      exp_we = 1'b0; exp_addr = 11'd0; exp_wdata = 32'd0; exp_strb = 4'd0;
    end
    check("cpu_gnt", bif.cpu_gnt, exp_gnt);
    check("mem_we", bif.mem_we, exp_we);
    if (host_act || perform || exp_we) check("mem_addr", bif.mem_addr, exp_addr);
    else check("mem_idle_addr", bif.mem_addr, 32'd0);
    if (exp_we) begin
      check("mem_wdata", bif.mem_wdata, exp_wdata);
      check("mem_wstrb", bif.mem_wstrb, exp_strb);
    end
    if (bif.host_re) check("host_rdata", bif.host_rdata, m_mem[bif.host_addr]);
    check("cpu_done", bif.cpu_done, m_done);
    check("cpu_rdata", bif.cpu_rdata, m_rdata);
    check("stall_cnt", bif.stall_cnt, m_stall);
    last_gnt = exp_gnt;
    @(posedge clk);
    if (bif.host_we) m_mem[bif.host_addr] = bif.host_wdata;
    if (riscv_rst) begin
      m_pend = 1'b0; m_done = 1'b0; m_stall = 16'd0;
    end else if (m_pend) begin
      if (host_act) begin
        if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      end else begin
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_strb[b]) m_mem[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
          m_rdata = m_mem[m_addr];
        end
        m_pend = 1'b0;
        m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (bif.cpu_req) begin
      m_we = bif.cpu_we; m_addr = bif.cpu_addr; m_wdata = bif.cpu_wdata; m_strb = bif.cpu_wstrb;
      m_pend = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic host_idle();
    bif.host_we = 1'b0; bif.host_re = 1'b0;
  endtask

  task automatic cpu_issue(input logic we, input logic [10:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb);
    bif.cpu_req = 1'b1; bif.cpu_we = we; bif.cpu_addr = addr;
    bif.cpu_wdata = wdata; bif.cpu_wstrb = strb;
  endtask

  initial begin
    rst_n = 1'b0; riscv_rst = 1'b0;
    host_idle();
    bif.host_addr = 11'd0; bif.host_wdata = 32'd0;
    bif.cpu_req = 1'b0; bif.cpu_we = 1'b0; bif.cpu_addr = 11'd0;
    bif.cpu_wdata = 32'd0; bif.cpu_wstrb = 4'd0;
    model_reset();
    last_gnt = 1'b0; prev_host = 1'b0;
    #12;
    check("rst_done", bif.cpu_done, 32'd0);
    check("rst_rdata", bif.cpu_rdata, 32'd0);
    check("rst_stall", bif.stall_cnt, 32'd0);
    check("rst_mem_we", bif.mem_we, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload the working window through host writes
    for (int a = 0; a < 32; a++) begin
      bif.host_we = 1'b1; bif.host_addr = 11'(a); bif.host_wdata = $urandom;
      step();
      host_idle();
      step();
    end

    // 1: host write then host read
    bif.host_we = 1'b1; bif.host_addr = 11'h005; bif.host_wdata = 32'hDEADBEEF;
    step();
    bif.host_we = 1'b0; bif.host_re = 1'b1;
    #1 check("t1_host_rdata", bif.host_rdata, 32'hDEADBEEF);
    step();
    host_idle();

    // 2: CPU read with known data
    bif.host_we = 1'b1; bif.host_addr = 11'h010; bif.host_wdata = 32'h12345678;
    step();
    host_idle();
    cpu_issue(1'b0, 11'h010, 32'd0, 4'd0);
    step();
    bif.cpu_req = 1'b0;
    step();
    #1 check("t2_done", bif.cpu_done, 32'd1);
    check("t2_rdata", bif.cpu_rdata, 32'h12345678);
    step();

    // 3: host conflict during ACCESS
    riscv_rst = 1'b1; step(); riscv_rst = 1'b0;
    cpu_issue(1'b1, 11'h011, 32'hCAFEF00D, 4'hF);
    step();
    bif.cpu_req = 1'b0; bif.host_re = 1'b1; bif.host_addr = 11'h005;
    step();
    host_idle();
    step();
    bif.host_re = 1'b1; bif.host_addr = 11'h011;
    #1 check("t3_done", bif.cpu_done, 32'd1);
    check("t3_host_rdata", bif.host_rdata, 32'hCAFEF00D);
    check("t3_stall", bif.stall_cnt, 32'd1);
    step();
    host_idle();

    // 4: byte strobes
    bif.host_we = 1'b1; bif.host_addr = 11'h020; bif.host_wdata = 32'hAABBCCDD;
    step();
    host_idle();
    cpu_issue(1'b1, 11'h020, 32'h11223344, 4'b0101);
    step();
    bif.cpu_req = 1'b0;
    step(); step();
    bif.host_re = 1'b1; bif.host_addr = 11'h020;
    #1 check("t4_host_rdata", bif.host_rdata, 32'hAA22CC44);
    step();
    host_idle();

    // 5: riscv_rst while the write is stalled by the host
    bif.host_we = 1'b1; bif.host_addr = 11'h012; bif.host_wdata = 32'h01010101;
    step();
    host_idle();
    cpu_issue(1'b1, 11'h012, 32'hFFFFFFFF, 4'hF);
    step();
    bif.cpu_req = 1'b0; riscv_rst = 1'b1; bif.host_we = 1'b1; bif.host_addr = 11'h003;
    step();
    host_idle(); riscv_rst = 1'b0;
    step();
    #1 check("t5_no_done", bif.cpu_done, 32'd0);
    check("t5_stall", bif.stall_cnt, 32'd0);
    step();
    bif.host_re = 1'b1; bif.host_addr = 11'h012;
    #1 check("t5_no_write", bif.host_rdata, 32'h01010101);
    step();
    host_idle();

    // 6: asynchronous reset in the middle of ACCESS
    cpu_issue(1'b1, 11'h013, 32'h5A5A5A5A, 4'hF);
    step();
    bif.cpu_req = 1'b0; bif.host_re = 1'b1; bif.host_addr = 11'h001;
    step();
    host_idle();
    #3 rst_n = 1'b0;
    #1 check("t6_stall_clr", bif.stall_cnt, 32'd0);
    check("t6_done_clr", bif.cpu_done, 32'd0);
    check("t6_rdata_clr", bif.cpu_rdata, 32'd0);
    check("t6_mem_we", bif.mem_we, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_issue(1'b0, 11'h013, 32'd0, 4'd0);
    #1 check("t6_gnt", bif.cpu_gnt, 32'd1);
    step();
    bif.cpu_req = 1'b0;
    step(); step(); step();

    // Random traffic
    last_gnt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (last_gnt) bif.cpu_req = 1'b0;
      host_idle();
      if (!prev_host && $urandom_range(2) == 0) begin
        if ($urandom_range(1) == 0) bif.host_we = 1'b1;
        else bif.host_re = 1'b1;
        bif.host_addr = 11'($urandom_range(31));
        bif.host_wdata = $urandom;
      end
      prev_host = bif.host_we | bif.host_re;
      riscv_rst = ($urandom_range(39) == 0);
      if (!bif.cpu_req && $urandom_range(1) == 0)
        cpu_issue(1'($urandom_range(1)), 11'($urandom_range(31)), $urandom, 4'($urandom_range(15)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
